ysyx_25040129_ifu_prefetch: RTL

Parametrised pipelined instruction fetch unit with a prefetch queue. It sits between the core's instruction bus master port and the IDU. It keeps up to `MAX_OUTSTANDING` read requests in flight, buffers returned instructions with their PCs in a `FIFO_DEPTH` queue, and discards stale in-flight responses after a pipeline flush. Issue stalls while any downstream stage holds a pending `satp` write.

---
 rtl/ysyx_25040129_pkg.sv | 11 +
 rtl/ysyx_25040129_sync_fifo.sv | 46 ++++
 rtl/ysyx_25040129_ifu_prefetch.sv | 115 +++++++++++
 3 files changed

// File: rtl/ysyx_25040129_pkg.sv
// ysyx_25040129_pkg: shared CSR constants, bus response codes and the fetch queue entry type
package ysyx_25040129_pkg;
    localparam int CSR_DIG = 12;
    localparam logic [CSR_DIG-1:0] CSR_SATP = 12'h180;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } fetch_entry_t;
endpackage

// File: rtl/ysyx_25040129_sync_fifo.sv
// ysyx_25040129_sync_fifo: power-of-two synchronous queue with clear and same-cycle push/pop
//   clk/rst (async, active-high), clear (sync flush), push/din, pop/dout (head), count, empty, full
module ysyx_25040129_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count,
    output logic             empty,
    output logic             full
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic do_push, do_pop;
    assign empty = count == '0;
    assign full = count == (AW+1)'(DEPTH);
    assign do_push = push && (!full || pop);
    assign do_pop = pop && !empty;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/ysyx_25040129_ifu_prefetch.sv
// ysyx_25040129_ifu_prefetch: pipelined fetch unit with prefetch queue, flush drop counting and satp hazard stall
//   clk/rst (async, active-high); pipeline_flush/_target redirect; IDU handshake (is_req_valid_to_idu,
//   is_req_ready_from_idu, pc, inst_to_idu, fault_to_idu); bus AR (araddr/arvalid/arready) and
//   R (rdata/rresp/rvalid/rready); csr_addr_flat/csr_wr_valid snoop ports.
//   Optional YSYX_25040129_IFU_FAULT_EN: track rresp errors per entry and halt fetch after a fault.
module ysyx_25040129_ifu_prefetch
    import ysyx_25040129_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int NUM_CSR_PORTS = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             pipeline_flush,
    input  logic [31:0]                      pipeline_flush_target,
    output logic                             is_req_valid_to_idu,
    input  logic                             is_req_ready_from_idu,
    output logic [31:0]                      pc,
    output logic [31:0]                      inst_to_idu,
    output logic                             fault_to_idu,
    output logic [31:0]                      araddr,
    output logic                             arvalid,
    input  logic                             arready,
    input  logic [31:0]                      rdata,
    input  logic [1:0]                       rresp,
    input  logic                             rvalid,
    output logic                             rready,
    input  logic [NUM_CSR_PORTS*CSR_DIG-1:0] csr_addr_flat,
    input  logic [NUM_CSR_PORTS-1:0]         csr_wr_valid
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef YSYX_25040129_IFU_FAULT_EN
    localparam int EW = $bits(fetch_entry_t);
`else
    localparam int EW = 64;
`endif
    logic [31:0] fetch_pc, resp_pc;
    logic [OW-1:0] outstanding, drop_cnt;
    logic [CW-1:0] fifo_count;
    logic [EW-1:0] fifo_din, fifo_dout;
    logic halted, raw, ar_fire, r_fire, push, pop, fault, empty, fifo_full_unused;
    always_comb begin
        raw = 1'b0;
        for (int i = 0; i < NUM_CSR_PORTS; i++)
            raw = raw | (csr_wr_valid[i] && csr_addr_flat[i*CSR_DIG +: CSR_DIG] == CSR_SATP);
    end
    // Queue space for every in-flight request is reserved at issue, so rready never needs to drop.
    assign arvalid = !rst && !raw && !halted && !pipeline_flush
                     && 32'(outstanding) < 32'(MAX_OUTSTANDING)
                     && 32'(outstanding) + 32'(fifo_count) < 32'(FIFO_DEPTH);
    assign araddr = fetch_pc;
    assign rready = 1'b1;
    assign ar_fire = arvalid && arready;
    assign r_fire = rvalid;
    assign push = r_fire && !pipeline_flush && drop_cnt == '0;
    assign is_req_valid_to_idu = !empty && !pipeline_flush;
    assign pop = is_req_valid_to_idu && is_req_ready_from_idu;
`ifdef YSYX_25040129_IFU_FAULT_EN
    fetch_entry_t head;
    assign fault = rresp != RESP_OKAY;
    assign fifo_din = {resp_pc, rdata, fault};
    assign head = fetch_entry_t'(fifo_dout);
    assign pc = head.pc;
    assign inst_to_idu = head.inst;
    assign fault_to_idu = head.fault;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) halted <= 1'b0;
        else if (pipeline_flush) halted <= 1'b0;
        else if (push && fault) halted <= 1'b1;
    end
`else
    logic unused_rresp;
    assign unused_rresp = ^rresp;
    assign fault = 1'b0;
    assign halted = fault;
    assign fifo_din = {resp_pc, rdata};
    assign pc = fifo_dout[63:32];
    assign inst_to_idu = fifo_dout[31:0];
    assign fault_to_idu = fault;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            resp_pc <= RESET_PC;
            outstanding <= '0;
            drop_cnt <= '0;
        end else if (pipeline_flush) begin
            // Every request still unanswered after this cycle belongs to the old stream.
            fetch_pc <= pipeline_flush_target;
            resp_pc <= pipeline_flush_target;
            outstanding <= outstanding - OW'(r_fire);
            drop_cnt <= outstanding - OW'(r_fire);
        end else begin
            if (ar_fire) fetch_pc <= fetch_pc + 32'd4;
            outstanding <= outstanding + OW'(ar_fire) - OW'(r_fire);
            if (r_fire && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
            if (push) resp_pc <= resp_pc + 32'd4;
        end
    end
    ysyx_25040129_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_fifo (
        .clk(clk),
        .rst(rst),
        .clear(pipeline_flush),
        .push(push),
        .din(fifo_din),
        .pop(pop),
        .dout(fifo_dout),
        .count(fifo_count),
        .empty(empty),
        .full(fifo_full_unused)
    );
endmodule
